usb_bus_signal_gen: RTL and testbench
=====================================

USB_BUS_SIGNAL_GEN -- requirements
Module: usb_bus_signal_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 60, clock frequency in MHz.
REQ-002 SHALL have parameter RESET_US, default 10000, bus-reset SE0 duration in microseconds.
REQ-003 SHALL have parameter RESUME_US, default 20000, host-resume K duration in microseconds.
REQ-004 SHALL have parameter WAKE_US, default 2000, remote-wakeup K duration in microseconds.
REQ-005 SHALL have parameter HOLDOFF_US, default 5000, minimum continuous idle J before remote wakeup, in microseconds.
REQ-006 SHALL have parameter EOP_CYCLES, default 80, SE0 length of the resume EOP, in clk cycles.
REQ-007 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port line_state, input, 2 bits, UTMI line state (00=SE0, 01=J, 10=K, 11=SE1).
REQ-010 SHALL have port cmd_valid, input, 1 bit, command request.
REQ-011 SHALL have port cmd, input, 2 bits, command code (00=bus reset, 01=host resume, 10=remote wakeup, 11=reserved).
REQ-012 SHALL have port cmd_ready, output, 1 bit, high only in IDLE.
REQ-013 SHALL have port abort, input, 1 bit, synchronous cancel of the current sequence.
REQ-014 SHALL have port drive_en, output, 1 bit, transmitter owns the bus.
REQ-015 SHALL have port drive_state, output, 2 bits, driven line level (00=SE0, 01=J, 10=K).
REQ-016 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit, one-cycle pulse at sequence completion or abort.

Function
REQ-018 SHALL implement states IDLE, HOLDOFF, RST_SE0, RES_K, EOP_SE0, EOP_J, WAKE_K.
REQ-019 SHALL accept a command on the cycle cmd_valid and cmd_ready are both high; cmd 11 SHALL be accepted, cause no bus activity, and give a done pulse on the next cycle.
REQ-020 SHALL move, on the cycle after acceptance, as follows: cmd 00 to RST_SE0; cmd 01 to RES_K; cmd 10 to HOLDOFF.
REQ-021 SHALL hold RST_SE0 for exactly CLK_FREQ_MHZ*RESET_US cycles, driving SE0, then go to IDLE.
REQ-022 SHALL hold RES_K for exactly CLK_FREQ_MHZ*RESUME_US cycles (K), then EOP_SE0 for exactly EOP_CYCLES cycles (SE0), then EOP_J for exactly 1 cycle (J), then go to IDLE.
REQ-023 SHALL stay in HOLDOFF with drive_en=0 until line_state==01 has held for CLK_FREQ_MHZ*HOLDOFF_US consecutive cycles; any other line_state value SHALL restart the count.
REQ-024 SHALL hold WAKE_K for exactly CLK_FREQ_MHZ*WAKE_US cycles (K), then go to IDLE with no EOP.
REQ-025 SHALL register drive_en and drive_state, so bus outputs change on the cycle the state is entered; drive_en=1 in RST_SE0, RES_K, EOP_SE0, EOP_J, WAKE_K only.
REQ-026 SHALL drive drive_state=01 whenever drive_en=0.
REQ-027 SHALL pulse done for 1 cycle on the first IDLE cycle after any sequence.
REQ-028 SHALL, when abort is high in any non-IDLE state, go to IDLE on the next cycle with drive_en=0 and a done pulse; abort in IDLE SHALL be ignored.
REQ-029 SHALL make abort take priority over duration expiry on the same cycle.
REQ-030 SHALL use one shared down-counter of 24 bits, loaded with duration-1 on state entry and saturating at 0; a zero-valued computed duration SHALL be treated as 1 cycle.

Reset
REQ-031 SHALL, while rst_n=0, set state=IDLE, counter=0, drive_en=0, drive_state=01, busy=0, done=0; cmd_ready SHALL go to 1 on the first cycle after release.
REQ-032 SHALL, on reset asserted mid-sequence, release the bus immediately (asynchronously) and SHALL NOT emit a done pulse.

Structure
REQ-033 SHALL place command codes, line-state codes and the state encoding in the shared USB package, alongside the line-monitor codes.
REQ-034 SHALL be a single module with no sub-modules; the duration computation SHALL be a localparam per state.

Verification (CLK_FREQ_MHZ=1, RESET_US=10, RESUME_US=8, WAKE_US=4, HOLDOFF_US=6, EOP_CYCLES=2)
REQ-035 SHALL verify: cmd=00 accepted -> SE0 driven for exactly 10 cycles, then drive_en=0 and done=1 for 1 cycle.
REQ-036 SHALL verify: cmd=01 -> K for 8 cycles, SE0 for 2 cycles, J for 1 cycle, then done.
REQ-037 SHALL verify: cmd=10 with line_state=J, K on cycle 3, then J -> no drive until 6 consecutive J cycles, then K for 4 cycles, then done.
REQ-038 SHALL verify: abort on cycle 5 of RST_SE0, and again on the expiry cycle -> IDLE next cycle, drive_en=0, single done pulse in each case.
REQ-039 SHALL verify: rst_n low during RES_K -> drive_en=0 at once, no done pulse; cmd=11 -> no drive, done on the next cycle; cmd_valid while busy -> command not accepted.

Source files
------------

// File: rtl/usb_bus_signal_gen_pkg.sv
// Shared USB definitions: UTMI line-state codes, bus-signal commands, the
// signal-generator state encoding and the line-monitor event codes.
package usb_bus_signal_gen_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    CMD_BUS_RESET   = 2'b00,
    CMD_HOST_RESUME = 2'b01,
    CMD_REMOTE_WAKE = 2'b10,
    CMD_RSVD        = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_RST_SE0,
    ST_RES_K,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_WAKE_K
  } sig_state_e;

  typedef enum logic [1:0] {
    LM_IDLE    = 2'b00,
    LM_RESET   = 2'b01,
    LM_RESUME  = 2'b10,
    LM_SUSPEND = 2'b11
  } lm_evt_e;

  // Counter load for a duration in cycles; a zero duration still lasts one cycle.
  function automatic logic [CNT_W-1:0] dur_load(input int unsigned cyc);
    int unsigned m1;
    m1 = (cyc == 0) ? 0 : cyc - 1;
    return m1[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/usb_bus_signal_gen.sv
// Host/device bus-signalling generator: bus reset (SE0), host resume (K + EOP)
// and remote wakeup (idle holdoff, then K), timed by one shared down-counter.
module usb_bus_signal_gen
  import usb_bus_signal_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 60,
  parameter int unsigned RESET_US     = 10000,
  parameter int unsigned RESUME_US    = 20000,
  parameter int unsigned WAKE_US      = 2000,
  parameter int unsigned HOLDOFF_US   = 5000,
  parameter int unsigned EOP_CYCLES   = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] line_state,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       drive_en,
  output logic [1:0] drive_state,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] RST_LD  = dur_load(CLK_FREQ_MHZ * RESET_US);
  localparam logic [CNT_W-1:0] RES_LD  = dur_load(CLK_FREQ_MHZ * RESUME_US);
  localparam logic [CNT_W-1:0] WAKE_LD = dur_load(CLK_FREQ_MHZ * WAKE_US);
  localparam logic [CNT_W-1:0] HOLD_LD = dur_load(CLK_FREQ_MHZ * HOLDOFF_US);
  localparam logic [CNT_W-1:0] EOP_LD  = dur_load(EOP_CYCLES);

  sig_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             drive_en_q, drive_en_d;
  logic [1:0]       drive_state_q, drive_state_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          unique case (cmd_e'(cmd))
            CMD_BUS_RESET:   begin state_d = ST_RST_SE0; cnt_d = RST_LD;  end
            CMD_HOST_RESUME: begin state_d = ST_RES_K;   cnt_d = RES_LD;  end
            CMD_REMOTE_WAKE: begin state_d = ST_HOLDOFF; cnt_d = HOLD_LD; end
            default:         done_d = 1'b1;
          endcase
        end
      end
      // Any non-J line state restarts the idle qualification window.
      ST_HOLDOFF: begin
        if (line_state != LS_J) cnt_d = HOLD_LD;
        else if (cnt_q == '0) begin state_d = ST_WAKE_K; cnt_d = WAKE_LD; end
      end
      ST_RST_SE0: if (cnt_q == '0) begin state_d = ST_IDLE; done_d = 1'b1; end
      ST_RES_K:   if (cnt_q == '0) begin state_d = ST_EOP_SE0; cnt_d = EOP_LD; end
      ST_EOP_SE0: if (cnt_q == '0) begin state_d = ST_EOP_J; cnt_d = '0; end
      ST_EOP_J:   begin state_d = ST_IDLE; done_d = 1'b1; end
      ST_WAKE_K:  if (cnt_q == '0) begin state_d = ST_IDLE; done_d = 1'b1; end
      default:    state_d = ST_IDLE;
    endcase
    // Abort overrides any expiry decided above.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b1;
    end

    cmd_ready_d   = (state_d == ST_IDLE);
    drive_en_d    = 1'b1;
    drive_state_d = LS_J;
    unique case (state_d)
      ST_RST_SE0, ST_EOP_SE0: drive_state_d = LS_SE0;
      ST_RES_K, ST_WAKE_K:    drive_state_d = LS_K;
      ST_EOP_J:               drive_state_d = LS_J;
      default:                drive_en_d    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
      drive_en_q    <= 1'b0;
      drive_state_q <= LS_J;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      cmd_ready_q   <= cmd_ready_d;
      drive_en_q    <= drive_en_d;
      drive_state_q <= drive_state_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign drive_en    = drive_en_q;
  assign drive_state = drive_state_q;

endmodule

// File: tb/tb_usb_bus_signal_gen.sv
// Scoreboard bench: each scenario pushes its cycle-by-cycle expected outputs,
// a negedge monitor pops one entry per cycle and compares.
module tb_usb_bus_signal_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] line_state;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       abort;
  logic       drive_en;
  logic [1:0] drive_state;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [5:0] q[$];

  usb_bus_signal_gen #(
    .CLK_FREQ_MHZ(1), .RESET_US(10), .RESUME_US(8), .WAKE_US(4),
    .HOLDOFF_US(6), .EOP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_state(line_state), .cmd_valid(cmd_valid),
    .cmd(cmd), .cmd_ready(cmd_ready), .abort(abort), .drive_en(drive_en),
    .drive_state(drive_state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {drive_en, drive_state, busy, done, cmd_ready}
  function automatic logic [5:0] mk(input logic de, input logic [1:0] ds,
                                     input logic bz, input logic dn, input logic rd);
    return {de, ds, bz, dn, rd};
  endfunction

  localparam logic [5:0] V_RST  = 6'b0_01_0_0_0;
  localparam logic [5:0] V_IDLE = 6'b0_01_0_0_1;
  localparam logic [5:0] V_DONE = 6'b0_01_0_1_1;
  localparam logic [5:0] V_HOLD = 6'b0_01_1_0_0;
  localparam logic [5:0] V_SE0  = 6'b1_00_1_0_0;
  localparam logic [5:0] V_K    = 6'b1_10_1_0_0;
  localparam logic [5:0] V_J    = 6'b1_01_1_0_0;

  always @(negedge clk) begin
    logic [5:0] got, exp;
    cyc <= cyc + 1;
    if (q.size() > 0) begin
      exp = q.pop_front();
      got = mk(drive_en, drive_state, busy, done, cmd_ready);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL trace cyc=%0d de_ds_busy_done_rdy got=%b required=%b", cyc, got, exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout %s: %0d entries left, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
  endtask

  initial begin
    rst_n = 1'b0; line_state = 2'b01; cmd_valid = 1'b0; cmd = 2'b00; abort = 1'b0;
    push_n(V_RST, 2);
    drain("reset_hold");
    rst_n = 1'b1;
    q.push_back(V_RST);
    push_n(V_IDLE, 2);
    drain("reset_release");

    // Bus reset: 10 cycles SE0, then done.
    issue(2'b00);
    q.push_back(V_IDLE); push_n(V_SE0, 10); q.push_back(V_DONE); q.push_back(V_IDLE);
    step(); cmd_valid = 1'b0;
    drain("bus_reset");

    // Host resume: K x8, SE0 x2, J x1, done.
    issue(2'b01);
    q.push_back(V_IDLE); push_n(V_K, 8); push_n(V_SE0, 2); q.push_back(V_J);
    q.push_back(V_DONE); q.push_back(V_IDLE);
    step(); cmd_valid = 1'b0;
    drain("host_resume");

    // Remote wakeup: K on holdoff cycle 3 restarts the 6-cycle J count.
    issue(2'b10);
    q.push_back(V_IDLE); push_n(V_HOLD, 9); push_n(V_K, 4);
    q.push_back(V_DONE); q.push_back(V_IDLE);
    line_state = 2'b01;
    step(); cmd_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      line_state = (k == 3) ? 2'b10 : 2'b01;
      step();
    end
    line_state = 2'b01;
    drain("remote_wake");

    // Abort on cycle 5 of bus reset.
    issue(2'b00);
    q.push_back(V_IDLE); push_n(V_SE0, 5); q.push_back(V_DONE); push_n(V_IDLE, 2);
    step(); cmd_valid = 1'b0;
    repeat (4) step();
    abort = 1'b1; step(); abort = 1'b0;
    drain("abort_c5");

    // Abort on the expiry cycle: still exactly one done.
    issue(2'b00);
    q.push_back(V_IDLE); push_n(V_SE0, 10); q.push_back(V_DONE); push_n(V_IDLE, 2);
    step(); cmd_valid = 1'b0;
    repeat (9) step();
    abort = 1'b1; step(); abort = 1'b0;
    drain("abort_expiry");

    // Abort while idle is ignored.
    abort = 1'b1;
    push_n(V_IDLE, 3);
    drain("abort_idle");
    abort = 1'b0;

    // Reserved command: no drive, done next cycle.
    issue(2'b11);
    q.push_back(V_IDLE); q.push_back(V_DONE); push_n(V_IDLE, 2);
    step(); cmd_valid = 1'b0;
    drain("cmd_rsvd");

    // cmd_valid held while busy must not be accepted.
    issue(2'b00);
    q.push_back(V_IDLE); push_n(V_SE0, 10); q.push_back(V_DONE); push_n(V_IDLE, 2);
    step(); cmd = 2'b01;
    repeat (10) step();
    cmd_valid = 1'b0;
    drain("busy_reject");

    // Reset during resume K: bus released immediately, no done afterwards.
    issue(2'b01);
    q.push_back(V_IDLE); push_n(V_K, 3); push_n(V_RST, 3); push_n(V_IDLE, 3);
    step(); cmd_valid = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (drive_en !== 1'b0 || drive_state !== 2'b01) begin
      fails++;
      $display("FAIL async_release de/ds got=%b/%b required=0/01", drive_en, drive_state);
    end
    step(); step();
    rst_n = 1'b1;
    drain("reset_mid_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
